// File: rtl/matgen_ctrl.sv
// Kyber matrix-A generation sequencer.
// Walks (i, j) in row-major order over the K x K matrix. For each entry it starts the XOF with
// the two index bytes, forwards WORDS squeezed 64-bit words to parse, then waits for parse to
// report the finished polynomial.
module matgen_ctrl #(
   parameter int unsigned K     = 3,
   parameter int unsigned WORDS = 96
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_start,
   input  logic        i_transpose,
   input  logic        i_abort,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_xof_start,
   output logic [15:0] o_xof_idx,
   input  logic        i_xof_ready,
   input  logic [63:0] i_xof_word,
   input  logic        i_xof_word_valid,
   output logic        o_xof_word_ready,
   output logic [63:0] o_parse_ibytes,
   output logic        o_parse_ibytes_valid,
   input  logic        i_parse_done,
   output logic [1:0]  o_poly_row,
   output logic [1:0]  o_poly_col,
   output logic        o_poly_valid
);

   localparam int unsigned CntW = $clog2(WORDS + 1);

   typedef enum logic [2:0] {StIdle, StStart, StStream, StWait, StDone} state_e;

   state_e          state_q, state_d;
   logic [1:0]      row_q, row_d;
   logic [1:0]      col_q, col_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            transpose_q, transpose_d;
   logic [63:0]     pdata_q;
   logic            pvalid_q;
   logic            xfer;
   logic            last_row, last_col;

   // Abort masks the handshake so no word is consumed on the cycle we bail out.
   assign xfer     = (state_q == StStream) && i_xof_word_valid && !i_abort;
   assign last_row = (row_q == 2'(K - 1));
   assign last_col = (col_q == 2'(K - 1));

   assign o_parse_ibytes       = pdata_q;
   assign o_parse_ibytes_valid = pvalid_q;
   assign o_poly_row           = row_q;
   assign o_poly_col           = col_q;

   // Next-state, index/counter updates and Moore/Mealy outputs.
   always_comb begin
      state_d          = state_q;
      row_d            = row_q;
      col_d            = col_q;
      cnt_d            = cnt_q;
      transpose_d      = transpose_q;
      o_busy           = (state_q != StIdle);
      o_done           = 1'b0;
      o_xof_start      = 1'b0;
      o_xof_idx        = '0;
      o_xof_word_ready = 1'b0;
      o_poly_valid     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               transpose_d = i_transpose;
               row_d       = '0;
               col_d       = '0;
               cnt_d       = '0;
               state_d     = StStart;
            end
         end
         StStart: begin
            o_xof_start = 1'b1;
            o_xof_idx   = transpose_q ? {6'b0, row_q, 6'b0, col_q} : {6'b0, col_q, 6'b0, row_q};
            if (i_xof_ready) begin
               state_d = StStream;
            end
         end
         StStream: begin
            o_xof_word_ready = !i_abort;
            if (xfer) begin
               if (cnt_q == CntW'(WORDS - 1)) begin
                  cnt_d   = '0;
                  state_d = StWait;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StWait: begin
            if (i_parse_done) begin
               o_poly_valid = 1'b1;
               if (last_col) begin
                  if (last_row) begin
                     state_d = StDone;
                  end else begin
                     col_d   = '0;
                     row_d   = row_q + 2'd1;
                     state_d = StStart;
                  end
               end else begin
                  col_d   = col_q + 2'd1;
                  state_d = StStart;
               end
            end
         end
         StDone: begin
            o_done  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Abort overrides everything above, including completion pulses.
      if (i_abort && (state_q != StIdle)) begin
         state_d      = StIdle;
         row_d        = '0;
         col_d        = '0;
         cnt_d        = '0;
         o_done       = 1'b0;
         o_poly_valid = 1'b0;
      end
   end

   // Control state registers.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= StIdle;
         row_q       <= '0;
         col_q       <= '0;
         cnt_q       <= '0;
         transpose_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cnt_q       <= cnt_d;
         transpose_q <= transpose_d;
      end
   end

   // One-cycle registered forwarding of accepted XOF words to parse.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         pdata_q  <= '0;
         pvalid_q <= 1'b0;
      end else begin
         pvalid_q <= xfer;
         if (xfer) begin
            pdata_q <= i_xof_word;
         end
      end
   end

endmodule

// File: tb/tb_matgen_ctrl.sv
// Self-checking bench for matgen_ctrl: directed runs with randomized handshakes, checked against
// the expected (i, j) walk computed arithmetically from the polynomial number.
module tb_matgen_ctrl;
   localparam int K     = 3;
   localparam int WORDS = 96;

   logic        i_clk = 1'b0;
   logic        i_rstn = 1'b0;
   logic        i_start = 1'b0;
   logic        i_transpose = 1'b0;
   logic        i_abort = 1'b0;
   logic        o_busy, o_done, o_xof_start;
   logic [15:0] o_xof_idx;
   logic        i_xof_ready = 1'b0;
   logic [63:0] i_xof_word = '0;
   logic        i_xof_word_valid = 1'b0;
   logic        o_xof_word_ready;
   logic [63:0] o_parse_ibytes;
   logic        o_parse_ibytes_valid;
   logic        i_parse_done = 1'b0;
   logic [1:0]  o_poly_row, o_poly_col;
   logic        o_poly_valid;

   matgen_ctrl #(.K(K), .WORDS(WORDS)) dut (
      .i_clk               (i_clk),
      .i_rstn              (i_rstn),
      .i_start             (i_start),
      .i_transpose         (i_transpose),
      .i_abort             (i_abort),
      .o_busy              (o_busy),
      .o_done              (o_done),
      .o_xof_start         (o_xof_start),
      .o_xof_idx           (o_xof_idx),
      .i_xof_ready         (i_xof_ready),
      .i_xof_word          (i_xof_word),
      .i_xof_word_valid    (i_xof_word_valid),
      .o_xof_word_ready    (o_xof_word_ready),
      .o_parse_ibytes      (o_parse_ibytes),
      .o_parse_ibytes_valid(o_parse_ibytes_valid),
      .i_parse_done        (i_parse_done),
      .o_poly_row          (o_poly_row),
      .o_poly_col          (o_poly_col),
      .o_poly_valid        (o_poly_valid)
   );

   always #5 i_clk = ~i_clk;

   int          total = 0;
   int          bad = 0;
   logic        exp_pv = 1'b0;
   logic [63:0] exp_pd = '0;
   bit          pd_known = 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge i_clk);
      #1;
   endtask

   // Parse output reflects the previous cycle's transfer; data holds between transfers.
   task automatic chk_parse(input string tag);
      chk({tag, "_pvalid"}, o_parse_ibytes_valid, exp_pv);
      if (pd_known) chk({tag, "_pdata"}, o_parse_ibytes, exp_pd);
   endtask

   task automatic upd(input bit xfer, input logic [63:0] word);
      exp_pv = xfer;
      if (xfer) begin
         exp_pd   = word;
         pd_known = 1'b1;
      end
   endtask

   // One matrix run. ab_poly < 0 means no abort; otherwise abort while word ab_word (1-based)
   // of polynomial ab_poly is offered.
   task automatic run_matrix(input bit tr, input int vpct, input int rdelay, input bit spur,
                             input int ab_poly, input int ab_word);
      int          r, c, w;
      logic [15:0] eidx;
      bit          v;
      logic [63:0] word;
      i_start     = 1'b1;
      i_transpose = tr;
      #1;
      chk("idle_busy", o_busy, 0);
      chk("idle_xstart", o_xof_start, 0);
      chk_parse("idle");
      upd(1'b0, '0);
      nxt();
      i_start     = 1'b0;
      i_transpose = ~tr;  // must not matter after acceptance
      for (int n = 0; n < K * K; n++) begin
         r    = n / K;
         c    = n % K;
         eidx = tr ? 16'((r << 8) | c) : 16'((c << 8) | r);
         for (int d = 0; d <= rdelay; d++) begin
            i_xof_ready      = (d == rdelay);
            i_xof_word_valid = 1'b1;
            i_xof_word       = {$urandom, $urandom};
            i_start          = spur && ($urandom_range(3) == 0);
            #1;
            chk("start_req", o_xof_start, 1);
            chk("start_idx", o_xof_idx, eidx);
            chk("start_wready", o_xof_word_ready, 0);
            chk("start_busy", o_busy, 1);
            chk_parse("start");
            upd(1'b0, '0);
            nxt();
         end
         i_xof_ready = 1'b0;
         w = 0;
         while (w < WORDS) begin
            v    = ($urandom_range(99) < vpct);
            word = {32'(n), 32'(w)};
            if (n == ab_poly && w == ab_word - 1) begin
               i_xof_word_valid = 1'b1;
               i_xof_word       = word;
               i_abort          = 1'b1;
               i_parse_done     = 1'b0;
               i_start          = 1'b0;
               #1;
               chk("abort_done", o_done, 0);
               chk("abort_pvalid", o_poly_valid, 0);
               nxt();
               i_abort          = 1'b0;
               i_xof_word_valid = 1'b0;
               #1;
               chk("abort_busy", o_busy, 0);
               chk("abort_done2", o_done, 0);
               chk("abort_xstart", o_xof_start, 0);
               chk("abort_wready", o_xof_word_ready, 0);
               pd_known = 1'b0;
               upd(1'b0, '0);
               nxt();
               #1;
               chk("abort_idle_busy", o_busy, 0);
               chk_parse("abort_idle");
               return;
            end
            i_xof_word_valid = v;
            i_xof_word       = v ? word : {$urandom, $urandom};
            i_parse_done     = spur && ($urandom_range(7) == 0);
            i_start          = spur && ($urandom_range(7) == 0);
            #1;
            chk("stream_wready", o_xof_word_ready, 1);
            chk("stream_xstart", o_xof_start, 0);
            chk("stream_poly", o_poly_valid, 0);
            chk("stream_busy", o_busy, 1);
            chk_parse("stream");
            upd(v, word);
            if (v) w++;
            nxt();
         end
         for (int t = 0; t < 5; t++) begin
            i_xof_word_valid = 1'b1;  // surplus words must be refused
            i_xof_word       = {$urandom, $urandom};
            i_parse_done     = (t == 4);
            i_start          = spur && ($urandom_range(3) == 0);
            #1;
            chk("wait_wready", o_xof_word_ready, 0);
            chk("wait_xstart", o_xof_start, 0);
            chk("wait_poly", o_poly_valid, (t == 4));
            chk("wait_done", o_done, 0);
            if (t == 4) begin
               chk("poly_row", o_poly_row, r);
               chk("poly_col", o_poly_col, c);
            end
            chk_parse("wait");
            upd(1'b0, '0);
            nxt();
         end
         i_parse_done = 1'b0;
      end
      i_xof_word_valid = 1'b0;
      i_start          = 1'b0;
      #1;
      chk("done_pulse", o_done, 1);
      chk("done_busy", o_busy, 1);
      chk("done_poly", o_poly_valid, 0);
      chk_parse("done");
      upd(1'b0, '0);
      nxt();
      #1;
      chk("after_done", o_done, 0);
      chk("after_busy", o_busy, 0);
      chk_parse("after");
      nxt();
   endtask

   initial begin
      #12;
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_xstart", o_xof_start, 0);
      chk("rst_idx", o_xof_idx, 0);
      chk("rst_wready", o_xof_word_ready, 0);
      chk("rst_pvalid", o_parse_ibytes_valid, 0);
      chk("rst_pdata", o_parse_ibytes, 0);
      chk("rst_poly", o_poly_valid, 0);
      chk("rst_row", o_poly_row, 0);
      chk("rst_col", o_poly_col, 0);
      i_rstn = 1'b1;
      nxt();
      run_matrix(1'b0, 100, 0, 1'b0, -1, 0);
      run_matrix(1'b1, 100, 10, 1'b0, -1, 0);
      run_matrix(1'b0, 50, 2, 1'b1, -1, 0);
      run_matrix(1'b0, 100, 0, 1'b0, 5, 50);
      run_matrix(1'b0, 60, 1, 1'b0, -1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/matgen_ctrl.md
Name: matgen_ctrl

Overview:
- Sequences generation of the Kyber public matrix A (K x K polynomials) by driving the XOF and the parse block.
- For each (i, j), in row-major order, it starts the XOF with the two index bytes, streams exactly WORDS 64-bit XOF output words into parse, then waits for parse to finish.
- After each polynomial it emits a tagged completion pulse, and it emits a done pulse after the last polynomial.
- Sits between the top-level KEM controller and the xof/parse pair.

Parameters:
K, 3, matrix dimension (2/3/4 for Kyber512/768/1024)
WORDS, 96, 64-bit words per polynomial fed to parse (768 bytes)

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  asynchronous active-low reset
i_start  input  1  start matrix generation (sampled only in IDLE)
i_transpose  input  1  generate A^T; latched on accepted i_start
i_abort  input  1  synchronous abort, returns to IDLE
o_busy  output  1  high in every state except IDLE
o_done  output  1  one-cycle pulse after last polynomial
o_xof_start  output  1  request XOF absorb/restart; held until i_xof_ready
o_xof_idx  output  16  {byte0, byte1} appended to rho; stable while o_xof_start
i_xof_ready  input  1  XOF accepts start this cycle
i_xof_word  input  64  XOF squeeze output word
i_xof_word_valid  input  1  i_xof_word valid
o_xof_word_ready  output  1  controller accepts word this cycle
o_parse_ibytes  output  64  word forwarded to parse
o_parse_ibytes_valid  output  1  o_parse_ibytes valid (one-cycle pulse per word)
i_parse_done  input  1  parse coeffs valid pulse
o_poly_row  output  2  row index i of completed polynomial
o_poly_col  output  2  column index j of completed polynomial
o_poly_valid  output  1  one-cycle pulse: polynomial (row,col) complete

Behaviour:
- Reset (async, i_rstn low) puts all outputs at 0, state IDLE, i=j=0, word counter 0, transpose latch 0.
- States: IDLE, START, STREAM, WAIT, DONE.
- IDLE:
  - i_start=1 → latch i_transpose, clear i, j and the counter, go to START.
  - o_busy=0.
- START:
  - o_xof_start=1.
  - o_xof_idx = transpose ? {i, j} : {j, i}; each byte is zero-extended from 2 bits.
  - Go to STREAM on the cycle where i_xof_ready=1.
- STREAM:
  - o_xof_word_ready=1; a word transfers when it is high together with i_xof_word_valid.
  - On a transfer: register the word into o_parse_ibytes and assert o_parse_ibytes_valid the next cycle (1-cycle latency), then increment the counter.
  - When the transfer brings the counter to WORDS: clear the counter and go to WAIT. o_xof_word_ready drops the same cycle the state changes.
  - o_parse_ibytes_valid=0 on cycles with no transfer; o_parse_ibytes holds its last value.
- WAIT:
  - On i_parse_done=1, pulse o_poly_valid for one cycle with o_poly_row=i, o_poly_col=j.
  - On the same edge:
    - if (i,j)=(K-1,K-1), go to DONE;
    - else if j=K-1, set j=0, i=i+1, go to START;
    - else set j=j+1 and go to START.
  - i_parse_done in any state other than WAIT is ignored.
- DONE: o_done=1 for one cycle, then IDLE.
- i_abort=1 in any non-IDLE state:
  - next state IDLE, counters cleared;
  - no o_done and no o_poly_valid that cycle;
  - abort has priority over every other transition.
- i_start while busy is ignored.
- Extra XOF words are never accepted beyond WORDS per polynomial.
- Total polynomials per run is K*K; o_poly_valid fires exactly K*K times, then o_done exactly once.

Test Plan:
- K=3, transpose=0, XOF always valid/ready, parse done 5 cycles after the 96th word → o_xof_idx sequence 0x0000,0x0100,0x0200,0x0001,...,0x0202; 9 o_poly_valid pulses in row-major order; o_done 1 cycle after the 9th.
- Same run with i_transpose=1 → o_xof_idx sequence 0x0000,0x0001,0x0002,0x0100,...; row/col tags unchanged.
- i_xof_word_valid toggled pseudo-randomly → exactly 96 o_parse_ibytes_valid pulses per polynomial, each one cycle after its transfer, data in order (incrementing pattern 0..95 checked); ready low in WAIT.
- i_xof_ready held low 10 cycles in START → o_xof_start and o_xof_idx stable for all 10 cycles; no words accepted.
- i_abort during the 50th word of polynomial (1,2) → IDLE next cycle, o_busy=0, no o_done. A new i_start restarts at (0,0) with 96 fresh words.
- Spurious i_parse_done in STREAM, and i_start pulses mid-run → no state or index change; the run completes normally.
